// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared types, pad constant and byte rounding for the JPEG VLC packer
package jpeg_pkg;

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_FLUSH  = 1'b1
    } state_t;

    localparam logic JPEG_PAD_BIT = 1'b1;

    function automatic int unsigned bytes_ceil(input int unsigned bits);
        return (bits + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/jpeg_vlc_outreg.sv
// rtl/jpeg_vlc_outreg.sv - output word register holding data/last/nbytes until the downstream accepts
module jpeg_vlc_outreg #(
    parameter int OUT_W = 32,
    parameter int NB_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [OUT_W-1:0] load_data,
    input  logic             load_last,
    input  logic [NB_W-1:0]  load_nbytes,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic [NB_W-1:0]  out_nbytes,
    output logic             last_taken
);

    // load is only raised while out_valid is low, so a pending word is never overwritten
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_nbytes <= '0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_data   <= load_data;
            out_last   <= load_last;
            out_nbytes <= load_nbytes;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    assign last_taken = out_valid && out_ready && out_last;

endmodule

// File: rtl/jpeg_vlc_packer.sv
// rtl/jpeg_vlc_packer.sv - MSB-first variable-length code packer with 1-padded flush; JPEG_VLC_STATS_EN adds bit_count
module jpeg_vlc_packer #(
    parameter int OUT_W  = 32,
    parameter int CODE_W = 16,
    parameter int LEN_W  = $clog2(CODE_W + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CODE_W-1:0]             in_code,
    input  logic [LEN_W-1:0]              in_len,
    input  logic                          in_flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_last,
    output logic [$clog2(OUT_W/8+1)-1:0]  out_nbytes
`ifdef JPEG_VLC_STATS_EN
   ,output logic [31:0]                   bit_count
`endif
);
    import jpeg_pkg::*;

    localparam int ACC_W  = OUT_W + CODE_W;
    localparam int FILL_W = $clog2(ACC_W);
    localparam int NB_W   = $clog2(OUT_W/8+1);
    localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

    state_t              state, state_n;
    logic [ACC_W-1:0]    acc, acc_n;
    logic [FILL_W-1:0]   fill, fill_n;
    logic [LEN_W-1:0]    len_c;
    logic [CODE_W-1:0]   code_mask;
    logic [ACC_W-1:0]    ins;
    logic [OUT_W-1:0]    pad;
    logic                xfer;
    logic                load, load_last, last_taken;
    logic [OUT_W-1:0]    load_data;
    logic [NB_W-1:0]     load_nbytes;

    assign len_c     = (in_len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : in_len;
    assign code_mask = {CODE_W{1'b1}} >> (LEN_W'(CODE_W) - len_c);
    // Left-justify the code inside a CODE_W slot at the top, then slide it down past the bits already held
    assign ins       = ({in_code & code_mask, {OUT_W{1'b0}}} << (LEN_W'(CODE_W) - len_c)) >> fill;
    assign pad       = {OUT_W{JPEG_PAD_BIT}} >> fill;

    assign in_ready  = reset && (state == ST_ACCEPT) && (fill < OUT_W_F) && !out_valid;
    assign xfer      = in_valid && in_ready;

    always_comb begin
        state_n     = state;
        acc_n       = acc;
        fill_n      = fill;
        load        = 1'b0;
        load_data   = acc[ACC_W-1 -: OUT_W];
        load_last   = 1'b0;
        load_nbytes = NB_W'(OUT_W/8);
        if (xfer) begin
            acc_n  = acc | ins;
            fill_n = fill + FILL_W'(len_c);
            if (in_flush) state_n = ST_FLUSH;
        end
        if (!out_valid) begin
            if (fill >= OUT_W_F) begin
                load      = 1'b1;
                load_last = (state == ST_FLUSH) && (fill == OUT_W_F);
                acc_n     = acc << OUT_W;
                fill_n    = fill - OUT_W_F;
            end else if (state == ST_FLUSH) begin
                // Covers both the partial tail and the empty-stream case (fill==0 gives an all-ones word)
                load        = 1'b1;
                load_data   = acc[ACC_W-1 -: OUT_W] | pad;
                load_last   = 1'b1;
                load_nbytes = NB_W'(bytes_ceil(32'(fill)));
                acc_n       = '0;
                fill_n      = '0;
            end
        end
        if ((state == ST_FLUSH) && last_taken) state_n = ST_ACCEPT;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_ACCEPT;
            acc   <= '0;
            fill  <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            fill  <= fill_n;
        end
    end

    jpeg_vlc_outreg #(
        .OUT_W (OUT_W),
        .NB_W  (NB_W)
    ) u_outreg (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_nbytes (load_nbytes),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_nbytes  (out_nbytes),
        .last_taken  (last_taken)
    );

`ifdef JPEG_VLC_STATS_EN
    logic clr_stats;

    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_count <= '0;
            clr_stats <= 1'b0;
        end else begin
            clr_stats <= last_taken;
            if (clr_stats)
                bit_count <= xfer ? 32'(len_c) : '0;
            else if (xfer)
                bit_count <= (bit_count > (32'hFFFF_FFFF - 32'(len_c))) ? 32'hFFFF_FFFF
                                                                         : bit_count + 32'(len_c);
        end
    end
`endif

endmodule
